// File: rtl/video_pkg.sv
// Shared definitions for the multi-mode video timing generator: mode codes,
// the timing record, the per-sample record carried through the sync delay line,
// and the lookup that turns a mode code into its raster timing.
package video_pkg;

  localparam int VIDEO_CW = 12;

  localparam logic [1:0] MODE_640X480  = 2'd0;
  localparam logic [1:0] MODE_800X600  = 2'd1;
  localparam logic [1:0] MODE_1280X720 = 2'd2;
  localparam logic [1:0] MODE_CUSTOM   = 2'd3;

  // Horizontal and vertical terms in raster order: active, front porch, sync, back porch.
  typedef struct packed {
    logic [15:0] ha;
    logic [15:0] hfp;
    logic [15:0] hs;
    logic [15:0] hbp;
    logic [15:0] va;
    logic [15:0] vfp;
    logic [15:0] vs;
    logic [15:0] vbp;
    logic        hpol;
    logic        vpol;
  } timing_t;

  // One raster sample; the polarity bits travel with it so that a mode switch
  // never re-interprets samples still in flight.
  typedef struct packed {
    logic polH;
    logic polV;
    logic hs;
    logic vs;
    logic de;
  } sample_t;

  function automatic timing_t mode_timing(input logic [1:0] mode, input timing_t custom);
    timing_t t;
    case (mode)
      MODE_640X480: t = '{ha: 16'd640, hfp: 16'd16, hs: 16'd96, hbp: 16'd48,
                          va: 16'd480, vfp: 16'd10, vs: 16'd2, vbp: 16'd33,
                          hpol: 1'b0, vpol: 1'b0};
      MODE_800X600: t = '{ha: 16'd800, hfp: 16'd40, hs: 16'd128, hbp: 16'd88,
                          va: 16'd600, vfp: 16'd1, vs: 16'd4, vbp: 16'd23,
                          hpol: 1'b1, vpol: 1'b1};
      MODE_1280X720: t = '{ha: 16'd1280, hfp: 16'd110, hs: 16'd40, hbp: 16'd220,
                           va: 16'd720, vfp: 16'd5, vs: 16'd5, vbp: 16'd20,
                           hpol: 1'b1, vpol: 1'b1};
      default: t = custom;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/vt_delay_line.sv
// Fixed-depth shift register used to line up sync/DE with renderer latency.
// DEPTH = 0 turns it into a plain wire.
module vt_delay_line #(
  parameter int             W     = 5,
  parameter int             DEPTH = 1,
  parameter logic [W-1:0]   INIT  = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_data = i_data;
    end else begin : g_shift
      logic [W-1:0] r_stage [DEPTH];

      // Advance one stage per clock; reset fills every stage with the idle sample
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= INIT;
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_multi.sv
// Runtime-selectable video timing generator. Raster counters run in the current
// mode; mode requests are held pending and only take effect at the frame boundary,
// so the display never sees a torn frame. Sync/DE pass through a delay line so they
// line up with the renderer's pixel output.
module video_timing_multi
  import video_pkg::*;
#(
  parameter int CW           = VIDEO_CW,
  parameter int DEFAULT_MODE = 0,
  parameter int PIPE_DELAY   = 1,
  parameter int C_HA         = 640,
  parameter int C_HFP        = 16,
  parameter int C_HS         = 96,
  parameter int C_HBP        = 48,
  parameter int C_VA         = 480,
  parameter int C_VFP        = 10,
  parameter int C_VS         = 2,
  parameter int C_VBP        = 33,
  parameter bit C_HPOL       = 1'b0,
  parameter bit C_VPOL       = 1'b0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [1:0]    mode_req,
  input  logic          mode_req_valid,
  output logic [1:0]    mode_cur,
  output logic          mode_ack,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam timing_t CUSTOM_TIM = '{ha: 16'(C_HA), hfp: 16'(C_HFP), hs: 16'(C_HS), hbp: 16'(C_HBP),
                                     va: 16'(C_VA), vfp: 16'(C_VFP), vs: 16'(C_VS), vbp: 16'(C_VBP),
                                     hpol: C_HPOL, vpol: C_VPOL};
  localparam logic [1:0] DEF_MODE    = 2'(DEFAULT_MODE);
  localparam timing_t    DEF_TIM     = mode_timing(DEF_MODE, CUSTOM_TIM);
  localparam sample_t    IDLE_SAMPLE = '{polH: DEF_TIM.hpol, polV: DEF_TIM.vpol,
                                         hs: 1'b0, vs: 1'b0, de: 1'b0};

  logic [CW-1:0] r_hCnt;
  logic [CW-1:0] r_vCnt;
  logic [1:0]    r_modeCur;
  logic [1:0]    r_modeStored;
  logic          r_pending;
  logic          r_ackPend;
  logic [15:0]   r_frameCnt;

  timing_t       w_tim;
  logic [CW-1:0] w_hActEnd;
  logic [CW-1:0] w_hSyncStart;
  logic [CW-1:0] w_hSyncEnd;
  logic [CW-1:0] w_hLast;
  logic [CW-1:0] w_vActEnd;
  logic [CW-1:0] w_vSyncStart;
  logic [CW-1:0] w_vSyncEnd;
  logic [CW-1:0] w_vLast;
  logic          w_hWrap;
  logic          w_boundary;
  logic          w_apply;
  logic          w_active;
  sample_t       w_rawSample;
  sample_t       w_dlySample;

  assign w_tim        = mode_timing(r_modeCur, CUSTOM_TIM);
  assign w_hActEnd    = CW'(w_tim.ha);
  assign w_hSyncStart = CW'(w_tim.ha + w_tim.hfp);
  assign w_hSyncEnd   = CW'(w_tim.ha + w_tim.hfp + w_tim.hs);
  assign w_hLast      = CW'(w_tim.ha + w_tim.hfp + w_tim.hs + w_tim.hbp - 16'd1);
  assign w_vActEnd    = CW'(w_tim.va);
  assign w_vSyncStart = CW'(w_tim.va + w_tim.vfp);
  assign w_vSyncEnd   = CW'(w_tim.va + w_tim.vfp + w_tim.vs);
  assign w_vLast      = CW'(w_tim.va + w_tim.vfp + w_tim.vs + w_tim.vbp - 16'd1);

  assign w_hWrap    = (r_hCnt == w_hLast);
  assign w_boundary = w_hWrap && (r_vCnt == w_vLast);
  // A strobe landing on the boundary itself wins over the old pending request
  // but must wait for the following boundary.
  assign w_apply    = w_boundary && r_pending && !mode_req_valid;
  assign w_active   = (r_hCnt < w_hActEnd) && (r_vCnt < w_vActEnd);

  assign w_rawSample = '{polH: w_tim.hpol,
                         polV: w_tim.vpol,
                         hs:   (r_hCnt >= w_hSyncStart) && (r_hCnt < w_hSyncEnd),
                         vs:   (r_vCnt >= w_vSyncStart) && (r_vCnt < w_vSyncEnd),
                         de:   w_active};

  // Raster position: h runs across the line, v steps each time h wraps
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (w_hWrap) begin
      r_hCnt <= '0;
      r_vCnt <= (r_vCnt == w_vLast) ? '0 : r_vCnt + 1'b1;
    end else begin
      r_hCnt <= r_hCnt + 1'b1;
    end
  end

  // Capture mode requests and switch modes only between frames
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending    <= 1'b0;
      r_modeStored <= DEF_MODE;
      r_modeCur    <= DEF_MODE;
      r_ackPend    <= 1'b0;
    end else begin
      r_ackPend <= w_apply;
      if (mode_req_valid) begin
        r_pending    <= 1'b1;
        r_modeStored <= mode_req;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      if (w_apply) r_modeCur <= r_modeStored;
    end
  end

  // Count completed frames; written every cycle so the count always reloads from itself
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frameCnt <= '0;
    end else begin
      r_frameCnt <= r_frameCnt + {15'd0, w_boundary};
    end
  end

  vt_delay_line #(
    .W     ($bits(sample_t)),
    .DEPTH (PIPE_DELAY),
    .INIT  (IDLE_SAMPLE)
  ) u_syncDelay (
    .clk    (clk),
    .resetn (resetn),
    .i_data (w_rawSample),
    .o_data (w_dlySample)
  );

  // Register every output; polarity is applied from the bit carried with each sample
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      mode_ack    <= 1'b0;
      hsync       <= ~DEF_TIM.hpol;
      vsync       <= ~DEF_TIM.vpol;
      de          <= 1'b0;
    end else begin
      x           <= w_active ? r_hCnt : '0;
      y           <= w_active ? r_vCnt : '0;
      line_start  <= (r_hCnt == '0);
      frame_start <= (r_hCnt == '0) && (r_vCnt == '0);
      mode_ack    <= r_ackPend;
      hsync       <= w_dlySample.hs ^ ~w_dlySample.polH;
      vsync       <= w_dlySample.vs ^ ~w_dlySample.polV;
      de          <= w_dlySample.de;
    end
  end

  assign mode_cur  = r_modeCur;
  assign frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_video_timing_multi.sv
// Bench for video_timing_multi. Uses a small custom mode as the default so whole
// frames are cheap, and only visits the first line of the big standard modes.
module tb_video_timing_multi;

  localparam int PD = 3;

  logic        clk;
  logic        resetn;
  logic [1:0]  mode_req;
  logic        mode_req_valid;
  logic [1:0]  mode_cur;
  logic        mode_ack;
  logic [11:0] x;
  logic [11:0] y;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;

  video_timing_multi #(
    .CW(12), .DEFAULT_MODE(3), .PIPE_DELAY(PD),
    .C_HA(8), .C_HFP(2), .C_HS(3), .C_HBP(2),
    .C_VA(4), .C_VFP(1), .C_VS(2), .C_VBP(1),
    .C_HPOL(1'b1), .C_VPOL(1'b0)
  ) dut (
    .clk(clk), .resetn(resetn), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode_cur(mode_cur), .mode_ack(mode_ack), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .de(de), .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference timing table, independent of the design's package
  typedef struct { int ha, hfp, hs, hbp, va, vfp, vs, vbp; bit hpol, vpol; } tim_t;

  function automatic tim_t tim(input int m);
    tim_t t;
    case (m)
      0:       t = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
      1:       t = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
      2:       t = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
      default: t = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b0};
    endcase
    return t;
  endfunction

  // Reference model state: position is a linear pixel index within the frame
  int          mMode, mStored, mPos;
  bit          mPend, mAckPend;
  logic [15:0] mFrameCnt;
  logic [2:0]  mPipe[$];
  int          eX, eY;
  logic        eAck, eHs, eVs, eDe, eLine, eFrame;

  function automatic logic [2:0] idleLevels(input int m);
    tim_t t = tim(m);
    return {~t.hpol, ~t.vpol, 1'b0};
  endfunction

  task automatic modelReset();
    mMode = 3; mStored = 3; mPos = 0; mPend = 0; mAckPend = 0; mFrameCnt = 16'd0;
    mPipe.delete();
    for (int i = 0; i < PD; i++) mPipe.push_back(idleLevels(3));
  endtask

  task automatic modelStep(input bit reqV, input int req);
    tim_t t = tim(mMode);
    int hTot = t.ha + t.hfp + t.hs + t.hbp;
    int vTot = t.va + t.vfp + t.vs + t.vbp;
    int h = mPos % hTot;
    int v = mPos / hTot;
    bit act  = (h < t.ha) && (v < t.va);
    bit hsOn = (h >= t.ha + t.hfp) && (h < t.ha + t.hfp + t.hs);
    bit vsOn = (v >= t.va + t.vfp) && (v < t.va + t.vfp + t.vs);
    bit last = (mPos == hTot * vTot - 1);
    bit apply;
    eX = act ? h : 0;
    eY = act ? v : 0;
    eLine  = (h == 0);
    eFrame = (mPos == 0);
    eAck   = mAckPend;
    mPipe.push_back({hsOn ? t.hpol : ~t.hpol, vsOn ? t.vpol : ~t.vpol, act});
    {eHs, eVs, eDe} = mPipe.pop_front();
    apply = last && mPend && !reqV;
    mAckPend = apply;
    if (reqV) begin
      mPend = 1; mStored = req;
    end else if (apply) begin
      mPend = 0;
    end
    if (apply) mMode = mStored;
    if (last) begin
      mPos = 0; mFrameCnt = mFrameCnt + 16'd1;
    end else begin
      mPos = mPos + 1;
    end
  endtask

  function automatic logic [63:0] dutVec();
    return {16'd0, mode_cur, mode_ack, x, y, hsync, vsync, de, line_start, frame_start, frame_cnt};
  endfunction

  function automatic logic [63:0] modelVec();
    return {16'd0, 2'(mMode), eAck, 12'(eX), 12'(eY), eHs, eVs, eDe, eLine, eFrame, mFrameCnt};
  endfunction

  function automatic logic [63:0] resetVec();
    tim_t t = tim(3);
    return {16'd0, 2'd3, 1'b0, 12'd0, 12'd0, ~t.hpol, ~t.vpol, 3'b000, 16'd0};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, step the model, sample at the next falling edge
  task automatic applyStimulus(input bit reqV, input int req);
    mode_req_valid = reqV;
    mode_req       = 2'(req);
    modelStep(reqV, req);
    @(posedge clk);
    @(negedge clk);
    checkOutput("cycle_outputs", dutVec(), modelVec());
    mode_req_valid = 1'b0;
  endtask

  task automatic applyReset();
    resetn = 1'b0;
    mode_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_values", dutVec(), resetVec());
    resetn = 1'b1;
    modelReset();
  endtask

  typedef struct { int mode; int lineLen; int hsWidth; int deWidth; bit hsLevel; } modeVec_t;

  initial begin
    modeVec_t vec[4];
    int       ackCnt;
    bit       got;
    int       lineLen, hsCnt, deCnt, deRise;
    logic [15:0] wrapVals[2];

    vec[0] = '{0, 800, 96, 640, 1'b0};
    vec[1] = '{1, 1056, 128, 800, 1'b1};
    vec[2] = '{2, 1650, 40, 1280, 1'b1};
    vec[3] = '{3, 15, 3, 8, 1'b1};
    wrapVals[0] = 16'hFFFF;
    wrapVals[1] = 16'h0000;

    resetn = 1'b0;
    mode_req = 2'd0;
    mode_req_valid = 1'b0;
    @(negedge clk);

    // Per-mode switch: ack timing, line length, sync width/polarity, DE width and delay
    for (int e = 0; e < 4; e++) begin
      applyReset();
      repeat (4) applyStimulus(0, 0);
      applyStimulus(1, vec[e].mode);
      got = 0;
      for (int k = 0; k < 400 && !got; k++) begin
        applyStimulus(0, 0);
        got = eAck;
      end
      checkOutput($sformatf("m%0d_ack_seen", e), 64'(got), 64'd1);
      checkOutput($sformatf("m%0d_ack_with_frame_start", e), 64'({mode_ack, frame_start}), 64'd3);
      lineLen = -1; hsCnt = 0; deCnt = 0; deRise = -1;
      for (int k = 1; k <= PD + vec[e].lineLen; k++) begin
        applyStimulus(0, 0);
        if (line_start && lineLen < 0) lineLen = k;
        if (k >= PD && k < PD + vec[e].lineLen) begin
          if (hsync == vec[e].hsLevel) hsCnt++;
          if (de) deCnt++;
        end
        if (de && deRise < 0) deRise = k;
      end
      checkOutput($sformatf("m%0d_line_len", e), 64'(lineLen), 64'(vec[e].lineLen));
      checkOutput($sformatf("m%0d_hsync_width", e), 64'(hsCnt), 64'(vec[e].hsWidth));
      checkOutput($sformatf("m%0d_de_width", e), 64'(deCnt), 64'(vec[e].deWidth));
      checkOutput($sformatf("m%0d_de_offset", e), 64'(deRise), 64'(PD));
      checkOutput($sformatf("m%0d_mode_cur", e), 64'(mode_cur), 64'(vec[e].mode));
    end

    // Two strobes in one frame: last one wins, single ack
    applyReset();
    ackCnt = 0;
    repeat (10) applyStimulus(0, 0);
    applyStimulus(1, 1);
    repeat (20) applyStimulus(0, 0);
    applyStimulus(1, 2);
    repeat (120) begin
      applyStimulus(0, 0);
      if (mode_ack) ackCnt++;
    end
    checkOutput("double_req_ack_count", 64'(ackCnt), 64'd1);
    checkOutput("double_req_mode", 64'(mode_cur), 64'd2);

    // Strobe on the boundary cycle replaces the pending request and waits a frame
    applyReset();
    repeat (3) applyStimulus(0, 0);
    applyStimulus(1, 2);
    for (int k = 0; k < 300 && mPos != 119; k++) applyStimulus(0, 0);
    checkOutput("boundary_reached", 64'(mPos), 64'd119);
    applyStimulus(1, 1);
    ackCnt = 0;
    repeat (119) begin
      applyStimulus(0, 0);
      if (mode_ack) ackCnt++;
    end
    checkOutput("boundary_no_early_ack", 64'(ackCnt), 64'd0);
    checkOutput("boundary_mode_held", 64'(mode_cur), 64'd3);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("boundary_late_ack", 64'({mode_ack, frame_start, mode_cur}), 64'({1'b1, 1'b1, 2'd1}));

    // Frame counter wrap
    applyReset();
    repeat (5) applyStimulus(0, 0);
    force dut.r_frameCnt = 16'hFFFE;
    mFrameCnt = 16'hFFFE;
    repeat (2) applyStimulus(0, 0);
    release dut.r_frameCnt;
    for (int f = 0; f < 2; f++) begin
      got = 0;
      for (int k = 0; k < 300 && !got; k++) begin
        applyStimulus(0, 0);
        got = eFrame;
      end
      checkOutput($sformatf("wrap_frame_%0d", f), 64'(frame_cnt), 64'(wrapVals[f]));
    end

    // Asynchronous reset in the middle of a line
    repeat (20) applyStimulus(0, 0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_reset", dutVec(), resetVec());
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    modelReset();
    repeat (5) applyStimulus(0, 0);

    // Random requests against the reference model
    applyReset();
    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 29) == 0)
        applyStimulus(1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3);
      else
        applyStimulus(0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
